// File: rtl/gshare_pht.sv
// Gshare branch direction predictor: PC^GHR-indexed saturating counters with an in-order queue of in-flight predictions.
// Optional resolve/mispredict statistics are enabled by defining PHT_STATS_EN.
module gshare_pht #(
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 4,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        lookup_ready,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        mispredict,
  output logic        resolve_err,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispred
);

  localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(QDEPTH);

  logic [CNT_W-1:0]  pht_q   [ENTRIES];
  logic [IDX_W-1:0]  qidx_q  [QDEPTH];
  logic              qpred_q [QDEPTH];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              pred_valid_q, pred_taken_q, mispredict_q, resolve_err_q;

  logic              push, pop, q_empty;
  logic [IDX_W-1:0]  lookup_idx, head_idx;
  logic              head_pred, lookup_pred;
  logic [CNT_W-1:0]  head_cnt, head_cnt_d;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

  assign q_empty      = (count_q == '0);
  assign lookup_ready = (count_q != CNT_FULL);
  assign push         = lookup_valid & lookup_ready;
  assign pop          = resolve_valid & ~q_empty;

  assign lookup_idx  = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign lookup_pred = pht_q[lookup_idx][CNT_W-1];
  assign head_idx    = qidx_q[rd_ptr_q];
  assign head_pred   = qpred_q[rd_ptr_q];
  assign head_cnt    = pht_q[head_idx];

  always_comb begin
    head_cnt_d = head_cnt;
    if (resolve_taken && head_cnt != CNT_MAX) begin
      head_cnt_d = head_cnt + 1'b1;
    end else if (!resolve_taken && head_cnt != '0) begin
      head_cnt_d = head_cnt - 1'b1;
    end
  end

  // A one-bit history has no older bits to keep.
  generate
    if (HIST_W == 1) begin : g_ghr1
      assign ghr_d = resolve_taken;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[HIST_W-2:0], resolve_taken};
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Lookup reads the pre-update counter even when it aliases the head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= '0;
      end
    end else if (pop) begin
      pht_q[head_idx] <= head_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qidx_q[wr_ptr_q]  <= lookup_idx;
      qpred_q[wr_ptr_q] <= lookup_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      pred_valid_q <= push;
      mispredict_q <= pop & (head_pred != resolve_taken);
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        pred_taken_q <= lookup_pred;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        ghr_q    <= ghr_d;
      end
      if (resolve_valid && q_empty) begin
        resolve_err_q <= 1'b1;
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign mispredict  = mispredict_q;
  assign resolve_err = resolve_err_q;

`ifdef PHT_STATS_EN
  logic [15:0] stat_branches_q, stat_mispred_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else if (pop) begin
      if (stat_branches_q != 16'hFFFF) begin
        stat_branches_q <= stat_branches_q + 16'd1;
      end
      if ((head_pred != resolve_taken) && (stat_mispred_q != 16'hFFFF)) begin
        stat_mispred_q <= stat_mispred_q + 16'd1;
      end
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_branches = 16'd0;
  assign stat_mispred  = 16'd0;
`endif

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Branch direction predictor built from an array of 2^IDX_W saturating counters.
- Each counter is indexed by the PC hashed (XOR) with a global history register (GHR).
- Sits in front of the fetch/branch unit: it answers lookups one cycle later and tracks in-flight predictions in an in-order queue.
- Counters and GHR are trained when branches resolve, and a registered mispredict pulse is raised for the redirect logic.

Parameters:
IDX_W, 4, PHT index width; table holds 2^IDX_W counters
CNT_W, 2, counter width; prediction is counter MSB
HIST_W, 4, GHR width; must be <= IDX_W, XORed into low index bits
QDEPTH, 4, in-flight prediction queue depth (power of 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
lookup_valid  input  1  branch lookup request this cycle
lookup_pc  input  32  branch PC; word-aligned, bits [1:0] ignored
lookup_ready  output  1  queue not full; lookup accepted only when valid&ready
pred_valid  output  1  registered; prediction for the lookup accepted last cycle
pred_taken  output  1  registered predicted direction
resolve_valid  input  1  oldest in-flight branch resolved this cycle
resolve_taken  input  1  actual direction of oldest branch
mispredict  output  1  registered one-cycle pulse, stored prediction != actual
resolve_err  output  1  sticky; resolve_valid arrived with queue empty
stat_branches  output  16  resolved-branch count (PHT_STATS_EN)
stat_mispred  output  16  mispredict count (PHT_STATS_EN)

Behaviour:
- Index: idx = lookup_pc[IDX_W+1:2] XOR {zero-extended GHR}, computed with the current-cycle GHR.
- Lookup:
  - Accepted when lookup_valid & lookup_ready.
  - Next cycle: pred_valid=1 and pred_taken = counter[idx][CNT_W-1], using the counter value before any same-cycle update.
  - The queue pushes {idx, pred_taken}.
  - Non-accepted cycle: pred_valid=0 next cycle; pred_taken holds its last value.
- lookup_ready = !(count == QDEPTH). It is combinational from the registered count and does not account for a same-cycle resolve pop.
- Resolve, queue non-empty:
  - Pop the head entry.
  - counter[head.idx]: if taken and counter < 2^CNT_W-1, increment; if not taken and counter > 0, decrement; otherwise hold (saturate).
  - GHR <= {GHR[HIST_W-2:0], resolve_taken}.
  - Next cycle: mispredict = (head.pred != resolve_taken).
- Resolve, queue empty: no counter/GHR/queue change, mispredict=0, resolve_err<=1. resolve_err clears only on reset.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - The lookup uses the pre-update GHR and pre-update counter, even when the lookup index equals the head index.
- Queue: circular buffer with rd/wr pointers of log2(QDEPTH) bits that wrap naturally, plus a count register of log2(QDEPTH)+1 bits.
- Reset:
  - All counters=0 (strongly not taken); GHR=0; queue empty.
  - pred_valid=0, pred_taken=0, mispredict=0, resolve_err=0, stats=0.
  - Reset mid-operation discards all in-flight entries; a lookup or resolve in the reset cycle is ignored.
- No combinational path from lookup_pc or resolve_* to any output.

Optional Feature:
- Macro: PHT_STATS_EN.
- Defined:
  - stat_branches increments on every resolve that pops an entry.
  - stat_mispred increments when that resolve mispredicts.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: no counter logic; both ports remain in the interface and are tied to 0.

Test Plan:
- Reset, then lookup pc=0x40 -> next cycle pred_valid=1, pred_taken=0; lookup_ready=1.
- Four lookups pc=0x40 (idx 0) without resolve -> lookup_ready=0 after 4th; 5th lookup_valid ignored, pred_valid=0 next cycle.
- Resolve taken x3 for branches at one idx, GHR held constant via HIST_W=1 build -> counter 0->1->2->3, 4th taken keeps 3. Per resolve, mispredict pulses 1,1,0 for stored preds 0,0,1.
- Same cycle: lookup idx 5 and resolve taken of head idx 5 with counter=1 -> pred_taken=0 (old value); counter becomes 2; count unchanged.
- resolve_valid with empty queue -> resolve_err=1 sticky, GHR unchanged, mispredict=0; reset clears resolve_err.
- PHT_STATS_EN: 10 resolves, 3 mispredicted -> stat_branches=10, stat_mispred=3. Reset mid-stream with 2 entries queued -> queue empty, next resolve sets resolve_err.
